fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter D, 12, program counter width in bits.
REQ-002 Parameter L, 4, jump-LUT index width; LUT depth is 2^L entries of D bits.
REQ-003 Parameter C, 16, cycle counter width.
REQ-004 Parameter START_ADDR, 0, PC value loaded on start.
REQ-005 Parameter MAX_ADDR, 2^D-1, PC value that ends a run if no jump is taken there.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  run request, level-sensitive.
REQ-009 stall  in  1  hold PC this cycle.
REQ-010 halt  in  1  decoded halt instruction at current PC.
REQ-011 absjump_en  in  1  take absolute jump to lut[lut_idx].
REQ-012 reljump_en  in  1  take relative jump by rel_off.
REQ-013 lut_idx  in  L  jump-LUT read index.
REQ-014 rel_off  in  8  signed two's-complement relative offset.
REQ-015 lut_we / lut_waddr / lut_wdata  in  1 / L / D  jump-LUT write port.
REQ-016 prog_ctr  out  D  current program counter.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  high in DONE.
REQ-019 cycle_cnt  out  C  cycles spent in RUN.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DONE; IDLE -> RUN when start=1.
REQ-021 On IDLE -> RUN transition prog_ctr SHALL load START_ADDR and cycle_cnt SHALL clear to 0 in the same edge.
REQ-022 In RUN with stall=1, prog_ctr SHALL hold and no jump/halt input SHALL be acted on.
REQ-023 In RUN with stall=0 and halt=1, state SHALL go to DONE and prog_ctr SHALL hold.
REQ-024 In RUN with stall=0, halt=0, absjump_en=1, next prog_ctr SHALL be lut[lut_idx]; absjump_en has priority over reljump_en.
REQ-025 In RUN with stall=0, halt=0, reljump_en=1 only, next prog_ctr SHALL be prog_ctr + sign-extended rel_off, modulo 2^D (wrap both directions).
REQ-026 In RUN with stall=0, no halt, no jump: if prog_ctr==MAX_ADDR state SHALL go to DONE with prog_ctr held, else prog_ctr SHALL increment by 1.
REQ-027 halt SHALL take priority over both jump enables.
REQ-028 cycle_cnt SHALL increment by 1 on every RUN cycle including stalls and SHALL saturate at 2^C-1.
REQ-029 DONE -> IDLE SHALL occur only when start=0; prog_ctr and cycle_cnt SHALL hold in DONE and IDLE.
REQ-030 LUT writes SHALL be accepted only in IDLE or DONE; lut_we in RUN SHALL be ignored.
REQ-031 LUT read SHALL be combinational; a write and an absolute-jump read of the same entry cannot coincide (REQ-030).
REQ-032 busy and done SHALL be registered state decodes, never both high.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, prog_ctr=0, cycle_cnt=0, busy=0, done=0.
REQ-034 Reset asserted mid-RUN SHALL abort the run; LUT contents need not be cleared.
REQ-035 After reset release, start already high SHALL enter RUN on the first rising edge.

Configuration
REQ-036 Macro FETCH_CYCLE_CNT_EN defined: cycle counter per REQ-028; undefined: no counter register, cycle_cnt tied to 0, port retained.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default widths for D, L, C.
REQ-038 Jump LUT SHALL be sub-module fetch_lut (2^L x D, one write port, one combinational read port).

Verification
REQ-039 Reset mid-run: assert reset=0 at PC=5 -> prog_ctr=0, busy=0, done=0 immediately, no edge needed.
REQ-040 Sequential run D=12: start=1, no jumps, halt at PC=9 -> prog_ctr 0..9, done high next edge, cycle_cnt=10.
REQ-041 Absolute jump: lut[3]=0x200 written in IDLE, absjump_en=1, reljump_en=1, lut_idx=3 at PC=4 -> next PC=0x200.
REQ-042 Relative wrap: PC=2, rel_off=-5 -> PC=0xFFD; PC=0xFFE, rel_off=+3 -> PC=0x001.
REQ-043 Stall and limit: MAX_ADDR=20, stall held 3 cycles at PC=7 -> PC stays 7, cycle_cnt +3; at PC=20 no jump -> DONE, PC stays 20.
REQ-044 LUT write in RUN ignored: lut_we=1 to entry 2 during RUN, later jump via entry 2 -> old value used; done clears only after start=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch controller slice.
// Optional feature macro used by fetch_ctrl: FETCH_CYCLE_CNT_EN.
package fetch_pkg;

   localparam int unsigned FETCH_D_DEF = 32'd12;  // program counter width
   localparam int unsigned FETCH_L_DEF = 32'd4;   // jump-LUT index width
   localparam int unsigned FETCH_C_DEF = 32'd16;  // cycle counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_lut.sv
// Jump target table: 2^L entries of D bits, one synchronous write port and
// one combinational read port. Contents are not reset.
module fetch_lut
   import fetch_pkg::*;
#(
   parameter int unsigned D = FETCH_D_DEF,
   parameter int unsigned L = FETCH_L_DEF
) (
   input  logic         clk,
   input  logic         we_i,
   input  logic [L-1:0] waddr_i,
   input  logic [D-1:0] wdata_i,
   input  logic [L-1:0] raddr_i,
   output logic [D-1:0] rdata_o
);

   logic [D-1:0] mem_q [2**L];

   // Store a new jump target when the controller permits a write.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter fetch controller: IDLE/RUN/DONE sequencing with stall,
// halt, absolute (LUT) and relative jumps, and an end-of-program limit.
// Define FETCH_CYCLE_CNT_EN to build the saturating RUN cycle counter;
// without it cycle_cnt is tied to zero.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned  D          = FETCH_D_DEF,
   parameter int unsigned  L          = FETCH_L_DEF,
   parameter int unsigned  C          = FETCH_C_DEF,
   parameter logic [D-1:0] START_ADDR = '0,
   parameter logic [D-1:0] MAX_ADDR   = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stall,
   input  logic         halt,
   input  logic         absjump_en,
   input  logic         reljump_en,
   input  logic [L-1:0] lut_idx,
   input  logic [7:0]   rel_off,
   input  logic         lut_we,
   input  logic [L-1:0] lut_waddr,
   input  logic [D-1:0] lut_wdata,
   output logic [D-1:0] prog_ctr,
   output logic         busy,
   output logic         done,
   output logic [C-1:0] cycle_cnt
);

   localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

   fetch_state_e state_q, state_d;
   logic [D-1:0] pc_q, pc_d;
   logic         busy_q, done_q;
   logic         lut_we_s;
   logic [D-1:0] lut_rdata_s;
   logic [D-1:0] rel_ext_s;

   // Table writes are blocked while a program is running so a jump read
   // never races a write to the same entry.
   assign lut_we_s  = lut_we & (state_q != RUN);
   assign rel_ext_s = {{(D-8){rel_off[7]}}, rel_off};

   fetch_lut #(
      .D (D),
      .L (L)
   ) u_lut (
      .clk     (clk),
      .we_i    (lut_we_s),
      .waddr_i (lut_waddr),
      .wdata_i (lut_wdata),
      .raddr_i (lut_idx),
      .rdata_o (lut_rdata_s)
   );

   // Next state and next PC; priority in RUN is stall, halt, absolute jump,
   // relative jump, end-of-program limit, then sequential increment.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (stall) begin
               pc_d = pc_q;
            end else if (halt) begin
               state_d = DONE;
            end else if (absjump_en) begin
               pc_d = lut_rdata_s;
            end else if (reljump_en) begin
               pc_d = pc_q + rel_ext_s;
            end else if (pc_q == MAX_ADDR) begin
               state_d = DONE;
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = pc_q;
         end
      endcase
   end

   // State, PC and registered status decodes of the upcoming state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign prog_ctr = pc_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef FETCH_CYCLE_CNT_EN
   localparam logic [C-1:0] CNT_ONE = {{(C-1){1'b0}}, 1'b1};
   localparam logic [C-1:0] CNT_MAX = '1;

   logic [C-1:0] cnt_q, cnt_d;

   // Count every RUN cycle (stalls included), clear on run start, saturate.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) && start) begin
         cnt_d = '0;
      end else if ((state_q == RUN) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycle_cnt = cnt_q;
`else
   assign cycle_cnt = {C{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the run rules.
module tb_fetch_ctrl;

   localparam int D    = 12;
   localparam int L    = 4;
   localparam int C    = 16;
   localparam int C2   = 4;
   localparam int MAXA = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, stall, halt, absjump_en, reljump_en, lut_we;
   logic [L-1:0]  lut_idx, lut_waddr;
   logic [7:0]    rel_off;
   logic [D-1:0]  lut_wdata;
   logic [D-1:0]  prog_ctr, prog_ctr2;
   logic          busy, done, busy2, done2;
   logic [C-1:0]  cycle_cnt;
   logic [C2-1:0] cycle_cnt2;

   fetch_ctrl #(.D(D), .L(L), .C(C), .START_ADDR(12'h000), .MAX_ADDR(12'd20)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
      .absjump_en(absjump_en), .reljump_en(reljump_en), .lut_idx(lut_idx),
      .rel_off(rel_off), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .prog_ctr(prog_ctr), .busy(busy), .done(done), .cycle_cnt(cycle_cnt));

   // Narrow-counter twin, shares all inputs; used for saturation checks.
   fetch_ctrl #(.D(D), .L(L), .C(C2), .START_ADDR(12'h000), .MAX_ADDR(12'd20)) dut2 (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
      .absjump_en(absjump_en), .reljump_en(reljump_en), .lut_idx(lut_idx),
      .rel_off(rel_off), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .prog_ctr(prog_ctr2), .busy(busy2), .done(done2), .cycle_cnt(cycle_cnt2));

   int errors = 0;
   int checks = 0;

   // Behavioural model
   bit m_run, m_done;
   int m_pc, m_cnt;
   int m_lut [16];

   function automatic int wrap(int v);
      return ((v % (1 << D)) + (1 << D)) % (1 << D);
   endfunction

   function automatic int exp_cnt(int w);
`ifdef FETCH_CYCLE_CNT_EN
      int lim;
      lim = (1 << w) - 1;
      return (m_cnt > lim) ? lim : m_cnt;
`else
      return 0;
`endif
   endfunction

   function automatic int cnt_const(int v);
`ifdef FETCH_CYCLE_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_done = 1'b0; m_pc = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      int off;
      if (!m_run && !m_done) begin
         if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
         if (start) begin
            m_run = 1'b1; m_pc = 0; m_cnt = 0;
         end
      end else if (m_done) begin
         if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
         if (!start) m_done = 1'b0;
      end else begin
         m_cnt++;
         if (stall) begin
         end else if (halt) begin
            m_run = 1'b0; m_done = 1'b1;
         end else if (absjump_en) begin
            m_pc = m_lut[lut_idx];
         end else if (reljump_en) begin
            off  = $signed(rel_off);
            m_pc = wrap(m_pc + off);
         end else if (m_pc == MAXA) begin
            m_run = 1'b0; m_done = 1'b1;
         end else begin
            m_pc = wrap(m_pc + 1);
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      start = 1'b0; stall = 1'b0; halt = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
      lut_we = 1'b0; lut_idx = '0; lut_waddr = '0; lut_wdata = '0; rel_off = 8'h00;
   endtask

   task automatic test_reset();
      logic [D-1:0] wd;
      reset = 1'b0;
      quiet_inputs();
      #3;
      checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", prog_ctr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 16; i++) begin
         wd = 12'($urandom_range(0, 4095));
         lut_we = 1'b1; lut_waddr = 4'(i); lut_wdata = wd;
         step();
      end
      lut_we = 1'b0;
      checks++; if (busy !== 1'b0 || prog_ctr !== 12'h000) begin
         errors++; $display("FAIL idle_after_fill: got busy=%b pc=%h want busy=0 pc=000", busy, prog_ctr);
      end
   endtask

   task automatic test_sequential();
      int guard;
      start = 1'b1;
      step();
      checks++; if (prog_ctr !== 12'h000 || busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL seq_enter: got pc=%h busy=%b done=%b want 000 1 0", prog_ctr, busy, done);
      end
      guard = 0;
      while (!m_done && guard < 20) begin
         halt = (m_pc == 9);
         step();
         guard++;
         checks++; if (prog_ctr !== 12'(m_pc)) begin
            errors++; $display("FAIL seq_pc: got %h want %h", prog_ctr, 12'(m_pc));
         end
      end
      halt = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0 || prog_ctr !== 12'd9) begin
         errors++; $display("FAIL seq_done: got done=%b busy=%b pc=%h want 1 0 009", done, busy, prog_ctr);
      end
      checks++; if (cycle_cnt !== 16'(cnt_const(10))) begin
         errors++; $display("FAIL seq_cnt: got %0d want %0d", cycle_cnt, cnt_const(10));
      end
      step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL seq_done_hold: got %b want 1", done); end
      start = 1'b0;
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || prog_ctr !== 12'd9 || cycle_cnt !== 16'(cnt_const(10))) begin
         errors++; $display("FAIL seq_idle: got done=%b busy=%b pc=%h cnt=%0d want 0 0 009 %0d",
                            done, busy, prog_ctr, cycle_cnt, cnt_const(10));
      end
   endtask

   task automatic test_absjump();
      int guard;
      lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'h200;
      step();
      lut_we = 1'b0; start = 1'b1;
      step();
      guard = 0;
      while (m_pc != 4 && guard < 10) begin step(); guard++; end
      absjump_en = 1'b1; reljump_en = 1'b1; lut_idx = 4'd3; rel_off = 8'h01;
      step();
      checks++; if (prog_ctr !== 12'h200 || busy !== 1'b1) begin
         errors++; $display("FAIL abs_jump: got pc=%h busy=%b want 200 1", prog_ctr, busy);
      end
      absjump_en = 1'b0; reljump_en = 1'b0; halt = 1'b1;
      step();
      halt = 1'b0;
      checks++; if (done !== 1'b1 || prog_ctr !== 12'h200) begin
         errors++; $display("FAIL abs_halt: got done=%b pc=%h want 1 200", done, prog_ctr);
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_relwrap();
      int guard;
      start = 1'b1;
      step();
      guard = 0;
      while (m_pc != 2 && guard < 10) begin step(); guard++; end
      reljump_en = 1'b1; rel_off = 8'hFB;
      step();
      checks++; if (prog_ctr !== 12'hFFD) begin errors++; $display("FAIL rel_neg_wrap: got %h want ffd", prog_ctr); end
      rel_off = 8'h01;
      step();
      checks++; if (prog_ctr !== 12'hFFE) begin errors++; $display("FAIL rel_plus1: got %h want ffe", prog_ctr); end
      rel_off = 8'h03;
      step();
      checks++; if (prog_ctr !== 12'h001) begin errors++; $display("FAIL rel_pos_wrap: got %h want 001", prog_ctr); end
      reljump_en = 1'b0; halt = 1'b1;
      step();
      halt = 1'b0; start = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL rel_idle: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_stall_limit();
      int guard;
      start = 1'b1;
      step();
      guard = 0;
      while (m_pc != 7 && guard < 10) begin step(); guard++; end
      stall = 1'b1; halt = 1'b1; absjump_en = 1'b1; reljump_en = 1'b1; rel_off = 8'h10;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (prog_ctr !== 12'd7 || busy !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got pc=%h busy=%b want 007 1", prog_ctr, busy);
         end
      end
      checks++; if (cycle_cnt !== 16'(cnt_const(10))) begin
         errors++; $display("FAIL stall_cnt: got %0d want %0d", cycle_cnt, cnt_const(10));
      end
      stall = 1'b0; halt = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
      guard = 0;
      while (!m_done && guard < 30) begin step(); guard++; end
      checks++; if (prog_ctr !== 12'd20 || done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL limit_done: got pc=%h done=%b busy=%b want 014 1 0", prog_ctr, done, busy);
      end
      checks++; if (cycle_cnt !== 16'(cnt_const(24))) begin
         errors++; $display("FAIL limit_cnt: got %0d want %0d", cycle_cnt, cnt_const(24));
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_lut_we_in_run();
      lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 12'h055;
      step();
      lut_we = 1'b0; start = 1'b1;
      step();
      lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 12'h3AB;
      step();
      lut_we = 1'b0; absjump_en = 1'b1; lut_idx = 4'd2;
      step();
      checks++; if (prog_ctr !== 12'h055) begin errors++; $display("FAIL lut_we_run: got %h want 055", prog_ctr); end
      absjump_en = 1'b0; halt = 1'b1;
      step();
      halt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold_start: got %b want 1", done); end
      end
      start = 1'b0;
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL done_clear: got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int guard;
      start = 1'b1;
      step();
      guard = 0;
      while (m_pc != 5 && guard < 10) begin step(); guard++; end
      reset = 1'b0;
      #1;
      checks++; if (prog_ctr !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== 16'd0) begin
         errors++; $display("FAIL async_reset: got pc=%h busy=%b done=%b cnt=%0d want 000 0 0 0",
                            prog_ctr, busy, done, cycle_cnt);
      end
      model_reset();
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || prog_ctr !== 12'h000) begin
         errors++; $display("FAIL reset_held: got busy=%b pc=%h want 0 000", busy, prog_ctr);
      end
      reset = 1'b1;
   endtask

   task automatic test_start_after_reset();
      step();
      checks++; if (busy !== 1'b1 || prog_ctr !== 12'h000 || cycle_cnt !== 16'd0) begin
         errors++; $display("FAIL start_after_reset: got busy=%b pc=%h cnt=%0d want 1 000 0", busy, prog_ctr, cycle_cnt);
      end
      halt = 1'b1;
      step();
      halt = 1'b0; start = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         start      = ($urandom_range(0, 7) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         halt       = ($urandom_range(0, 19) == 0);
         absjump_en = ($urandom_range(0, 5) == 0);
         reljump_en = ($urandom_range(0, 4) == 0);
         lut_idx    = 4'($urandom_range(0, 15));
         rel_off    = 8'($urandom_range(0, 255));
         lut_we     = ($urandom_range(0, 2) == 0);
         lut_waddr  = 4'($urandom_range(0, 15));
         lut_wdata  = 12'($urandom_range(0, 4095));
         step();
         checks++; if (prog_ctr !== 12'(m_pc)) begin
            errors++; $display("FAIL rnd_pc: cycle %0d got %h want %h", n, prog_ctr, 12'(m_pc));
         end
         checks++; if (busy !== m_run || done !== m_done) begin
            errors++; $display("FAIL rnd_state: cycle %0d got busy=%b done=%b want %b %b", n, busy, done, m_run, m_done);
         end
         checks++; if (cycle_cnt !== 16'(exp_cnt(C))) begin
            errors++; $display("FAIL rnd_cnt: cycle %0d got %0d want %0d", n, cycle_cnt, exp_cnt(C));
         end
         checks++; if (cycle_cnt2 !== 4'(exp_cnt(C2))) begin
            errors++; $display("FAIL rnd_cnt_sat: cycle %0d got %0d want %0d", n, cycle_cnt2, exp_cnt(C2));
         end
      end
      quiet_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_absjump();
      test_relwrap();
      test_stall_limit();
      test_lut_we_in_run();
      test_reset_mid_run();
      test_start_after_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
